// File: rtl/adder_share_ctrl.sv
// -----------------------------------------------------------------------------
// adder_share_ctrl
//   Two requesters share a single 4-bit adder slice. An accepted operation is
//   processed one 4-bit slice per clock (LSB first), rippling the carry through
//   a register, and the W-bit result is then presented on a valid/ready
//   response port tagged with the owning requester's id.
//
// Parameters
//   WORDS        number of 4-bit slices per operand (W = 4*WORDS)
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   reqN_valid   requester N has an operation pending
//   reqN_ready   requester N accepted this cycle (combinational, IDLE only)
//   reqN_a/b     W-bit operands
//   reqN_cin     carry-in
//   rsp_valid    result available (held until rsp_ready)
//   rsp_ready    consumer takes the result
//   rsp_id       owning requester of the result
//   rsp_sum      W-bit sum, modulo 2^W
//   rsp_cout     carry out of the MSB slice
//   rsp_ovf      signed overflow of the W-bit add (only with ADDER_SHARE_OVF_EN)
//
// Build option
//   `define ADDER_SHARE_OVF_EN  adds the rsp_ovf port and its logic.
// -----------------------------------------------------------------------------
module adder_share_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [4*WORDS-1:0]   req0_a,
    input  logic [4*WORDS-1:0]   req0_b,
    input  logic [4*WORDS-1:0]   req1_a,
    input  logic [4*WORDS-1:0]   req1_b,
    input  logic                 req0_cin,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*WORDS-1:0]   rsp_sum,
`ifdef ADDER_SHARE_OVF_EN
    output logic                 rsp_ovf,
`endif
    output logic                 rsp_cout
);

    localparam int W  = 4 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The shared slice: 4-bit add with carry, result is {cout, sum[3:0]}.
    function automatic logic [4:0] slice_add(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       c);
        slice_add = {1'b0, a} + {1'b0, b} + {4'd0, c};
    endfunction

    state_t          state_r;
    state_t          state_s;

    logic            last_r;      // requester served most recently
    logic            id_r;
    logic [W-1:0]    a_r;         // operands shift right one slice per RUN cycle
    logic [W-1:0]    b_r;
    logic [W-1:0]    acc_r;       // sum slices shift in from the top
    logic            carry_r;
    logic [CW-1:0]   cnt_r;

    logic            rsp_valid_r;
    logic            rsp_id_r;
    logic [W-1:0]    rsp_sum_r;
    logic            rsp_cout_r;

`ifdef ADDER_SHARE_OVF_EN
    logic            ovf_acc_r;
    logic            rsp_ovf_r;
`endif

    logic            grant_s;
    logic            ready0_s;
    logic            ready1_s;
    logic            accept_s;
    logic            last_slice_s;
    logic            hs_s;
    logic [4:0]      slice_s;
    logic [W-1:0]    acc_next_s;

    // Round-robin arbitration and combinational ready generation.
    always_comb begin
        grant_s  = 1'b0;
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_r;
        end else begin
            grant_s = req1_valid;
        end
        // Ready is suppressed during the reset cycle and outside IDLE.
        if ((state_r == IDLE) && !reset) begin
            ready0_s = req0_valid & ~grant_s;
            ready1_s = req1_valid &  grant_s;
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign accept_s     = ready0_s | ready1_s;
    assign last_slice_s = (cnt_r == CW'(WORDS - 1));
    assign hs_s         = rsp_valid_r & rsp_ready;
    assign slice_s      = slice_add(a_r[3:0], b_r[3:0], carry_r);

    // Next accumulator value: newest slice enters at the top.
    generate
        if (WORDS == 1) begin : g_acc_one
            assign acc_next_s = slice_s[3:0];
        end else begin : g_acc_many
            assign acc_next_s = {slice_s[3:0], acc_r[W-1:4]};
        end
    endgenerate

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_slice_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture on accept and slice-serial datapath during RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r    <= 1'b1;
            id_r      <= 1'b0;
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            acc_r     <= {W{1'b0}};
            carry_r   <= 1'b0;
            cnt_r     <= {CW{1'b0}};
`ifdef ADDER_SHARE_OVF_EN
            ovf_acc_r <= 1'b0;
`endif
        end else if (accept_s) begin
            last_r  <= grant_s;
            id_r    <= grant_s;
            a_r     <= grant_s ? req1_a   : req0_a;
            b_r     <= grant_s ? req1_b   : req0_b;
            carry_r <= grant_s ? req1_cin : req0_cin;
            acc_r   <= {W{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            a_r     <= a_r >> 4;
            b_r     <= b_r >> 4;
            acc_r   <= acc_next_s;
            carry_r <= slice_s[4];
            cnt_r   <= last_slice_s ? {CW{1'b0}} : (cnt_r + CW'(1));
`ifdef ADDER_SHARE_OVF_EN
            // Carry into this slice's MSB is recoverable as s^a^b at bit 3;
            // the value left after the last slice is the full-width result.
            ovf_acc_r <= slice_s[4] ^ (slice_s[3] ^ a_r[3] ^ b_r[3]);
`endif
        end
    end

    // Registered response port: loaded one cycle after entering DONE,
    // reloaded with identical values while waiting, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_sum_r   <= {W{1'b0}};
            rsp_cout_r  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf_r   <= 1'b0;
`endif
        end else if ((state_r == DONE) && !hs_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_sum_r   <= acc_r;
            rsp_cout_r  <= carry_r;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf_r   <= ovf_acc_r;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_sum_r   <= {W{1'b0}};
            rsp_cout_r  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf_r   <= 1'b0;
`endif
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_sum    = rsp_sum_r;
    assign rsp_cout   = rsp_cout_r;
`ifdef ADDER_SHARE_OVF_EN
    assign rsp_ovf    = rsp_ovf_r;
`endif

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 4: number of 4-bit slices per operand; data width W = 4*WORDS.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each: requester N has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 each: requester N's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W each: operands.
REQ-007 The block SHALL have ports req0_cin / req1_cin, input, 1 each: carry-in.
REQ-008 The block SHALL have port rsp_valid, output, 1: result available.
REQ-009 The block SHALL have port rsp_ready, input, 1: consumer takes the result.
REQ-010 The block SHALL have port rsp_id, output, 1: index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_sum, output, W: sum.
REQ-012 The block SHALL have port rsp_cout, output, 1: carry out of the MSB slice.

Function
REQ-013 The block SHALL share one 4-bit adder slice (4-bit a, 4-bit b, 1-bit carry in; 4-bit sum, 1-bit carry out) between both requesters, processing one slice per cycle.
REQ-014 The block SHALL have FSM states IDLE, RUN and DONE: IDLE->RUN on accept; RUN->DONE after WORDS RUN cycles; DONE->IDLE when rsp_valid and rsp_ready are both high.
REQ-015 reqN_ready SHALL be combinational and high only in IDLE, and only for the granted requester; both ready signals SHALL never be high in the same cycle.
REQ-016 An accept SHALL occur on the clock edge where the granted reqN_valid and reqN_ready are both high.
REQ-017 Grant SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester not served last is granted.
REQ-018 On accept, the block SHALL capture operands, cin and id into internal registers; input changes after accept SHALL have no effect.
REQ-019 RUN cycle k (k = 0..WORDS-1) SHALL add slice k of both operands: carry in = captured cin for k = 0, otherwise the registered carry from slice k-1.
REQ-020 rsp_valid SHALL assert exactly WORDS+1 clock edges after the accept edge (with WORDS=4, 5 edges after accept) and hold until the rsp_valid/rsp_ready handshake.
REQ-021 rsp_sum, rsp_cout and rsp_id SHALL be stable while rsp_valid is high, and SHALL be 0 whenever rsp_valid is low.
REQ-022 Back-to-back operation SHALL have no bypass: a new accept occurs no earlier than the cycle after the DONE handshake.
REQ-023 Sum SHALL wrap modulo 2^W, with the overflow bit reported only on rsp_cout.
REQ-024 The adder slice SHALL be used only in RUN; reqN_valid asserted in RUN or DONE SHALL be held off (ready low) without loss.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL go to IDLE; rsp_valid, rsp_id, rsp_sum and rsp_cout SHALL be 0; the carry register and slice counter SHALL be 0; last-served SHALL be 1, so req0 wins the first tie.
REQ-026 Reset in RUN or DONE SHALL abort the operation with no response; reqN_ready SHALL be 0 during the reset cycle.

Configuration
REQ-027 With macro ADDER_SHARE_OVF_EN defined, the block SHALL add output port rsp_ovf (1 bit): two's-complement signed overflow of the full W-bit add (carry into MSB XOR carry out of MSB), following the same timing and zero rules as rsp_sum.
REQ-028 With ADDER_SHARE_OVF_EN undefined, the block SHALL have no rsp_ovf port and no related logic; all other behaviour is identical.

Verification
REQ-029 req0: a=0x0001, b=0x000B, cin=0, rsp_ready=1 -> rsp_valid 5 edges after accept; sum=0x000C, cout=0, id=0.
REQ-030 req1: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, id=1 (carry ripples through all 4 slices); a=0xAAAA, b=0x5555, cin=1 -> sum=0x0000, cout=1.
REQ-031 Both valid continuously from reset -> grant order req0, req1, req0, ...; ready signals never overlap; each result carries the correct id.
REQ-032 rsp_ready held low 3 cycles in DONE -> rsp_* stable, both ready signals 0; handshake on the 4th cycle -> IDLE, next accept one cycle later.
REQ-033 Reset asserted in the 2nd RUN cycle -> no rsp_valid, all outputs 0; next tie after reset grants req0.
REQ-034 With ADDER_SHARE_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0; a=0xFFFF, b=0x0001 -> ovf=0, cout=1.
